// File: rtl/joypad_pkg.sv
// Shared definitions for the keyboard-to-NES-joypad bridge: button indices,
// scan decoder states and the scan-code key map.
package joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } scan_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic       player;
    logic [2:0] button;
  } key_entry_t;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] button;
  } key_hit_t;

  localparam int NUM_KEYS = 16;

  localparam key_entry_t KEY_MAP [NUM_KEYS] = '{
    '{1'b0, 8'h1A, 1'b0, 3'(BTN_A)},
    '{1'b0, 8'h22, 1'b0, 3'(BTN_B)},
    '{1'b0, 8'h21, 1'b0, 3'(BTN_SELECT)},
    '{1'b0, 8'h2A, 1'b0, 3'(BTN_START)},
    '{1'b1, 8'h75, 1'b0, 3'(BTN_UP)},
    '{1'b1, 8'h72, 1'b0, 3'(BTN_DOWN)},
    '{1'b1, 8'h6B, 1'b0, 3'(BTN_LEFT)},
    '{1'b1, 8'h74, 1'b0, 3'(BTN_RIGHT)},
    '{1'b0, 8'h3B, 1'b1, 3'(BTN_A)},
    '{1'b0, 8'h42, 1'b1, 3'(BTN_B)},
    '{1'b0, 8'h3C, 1'b1, 3'(BTN_SELECT)},
    '{1'b0, 8'h43, 1'b1, 3'(BTN_START)},
    '{1'b0, 8'h1D, 1'b1, 3'(BTN_UP)},
    '{1'b0, 8'h1B, 1'b1, 3'(BTN_DOWN)},
    '{1'b0, 8'h1C, 1'b1, 3'(BTN_LEFT)},
    '{1'b0, 8'h23, 1'b1, 3'(BTN_RIGHT)}
  };

  // Both the code and the E0 flag must agree, so bare keypad 75 never hits Up.
  function automatic key_hit_t lookup_key(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_MAP[i].ext == ext && KEY_MAP[i].code == code) begin
        r.hit    = 1'b1;
        r.player = KEY_MAP[i].player;
        r.button = KEY_MAP[i].button;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] socd_filter(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      r[BTN_UP]   = 1'b0;
      r[BTN_DOWN] = 1'b0;
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      r[BTN_LEFT]  = 1'b0;
      r[BTN_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Tracks E0/F0 prefixes of an AT scan-code stream and flags each completed
// make or break event for the byte that finishes it.
module ps2_scan_decoder
  import joypad_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_clk,
  output logic       valid,
  output logic       ext,
  output logic       brk,
  output logic [7:0] code
);

  scan_state_t state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (ps2_data_clk) begin
      case (state)
        ST_IDLE: begin
          if (ps2_data == 8'hE0)      state <= ST_EXT;
          else if (ps2_data == 8'hF0) state <= ST_BRK;
        end
        ST_EXT: begin
          if (ps2_data == 8'hF0) state <= ST_EXT_BRK;
          else                   state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The event is flagged in the same cycle as the final byte so the button
  // registers can update on the very next edge.
  always_comb begin
    valid = 1'b0;
    ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
    code  = ps2_data;
    if (ps2_data_clk) begin
      case (state)
        ST_IDLE: valid = (ps2_data != 8'hE0) && (ps2_data != 8'hF0);
        ST_EXT:  valid = (ps2_data != 8'hF0);
        default: valid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/kbd_joypad.sv
// PS/2 keyboard to NES controller bridge: key map lookup, live button state
// and the $4016/$4017 strobe/serial-read shift registers.
module kbd_joypad
  import joypad_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int SOCD    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           ps2_data,
  input  logic                 ps2_data_clk,
  input  logic                 strobe_we,
  input  logic                 strobe_din,
  input  logic                 rd_en,
  input  logic                 rd_port,
  output logic                 rd_bit,
  output logic [8*PLAYERS-1:0] joy
);

  logic       dec_valid;
  logic       dec_ext;
  logic       dec_brk;
  logic [7:0] dec_code;
  key_hit_t   hit;
  logic       strobe;
  logic       reload;
  logic [7:0] sh   [PLAYERS];
  logic [7:0] filt [PLAYERS];

  ps2_scan_decoder u_decoder (
    .clock        (clock),
    .reset        (reset),
    .ps2_data     (ps2_data),
    .ps2_data_clk (ps2_data_clk),
    .valid        (dec_valid),
    .ext          (dec_ext),
    .brk          (dec_brk),
    .code         (dec_code)
  );

  assign hit = lookup_key(dec_ext, dec_code);

  always_ff @(posedge clock) begin
    if (reset) begin
      joy <= '0;
    end else if (dec_valid && hit.hit) begin
      for (int p = 0; p < PLAYERS; p++) begin
        for (int b = 0; b < 8; b++) begin
          if (hit.player == 1'(p) && hit.button == 3'(b)) joy[8*p+b] <= !dec_brk;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      filt[p] = (SOCD != 0) ? socd_filter(joy[8*p +: 8]) : joy[8*p +: 8];
    end
  end

  // A strobe write of 1 reloads immediately, overriding a same-cycle shift.
  assign reload = strobe || (strobe_we && strobe_din);

  always_ff @(posedge clock) begin
    if (reset) begin
      strobe <= 1'b0;
      rd_bit <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) sh[p] <= '0;
    end else begin
      if (strobe_we) strobe <= strobe_din;
      if (rd_en) begin
        rd_bit <= 1'b0;
        for (int p = 0; p < PLAYERS; p++) begin
          if (rd_port == 1'(p)) rd_bit <= strobe ? joy[8*p] : sh[p][0];
        end
      end
      for (int p = 0; p < PLAYERS; p++) begin
        if (reload)                           sh[p] <= filt[p];
        else if (rd_en && rd_port == 1'(p))   sh[p] <= {1'b1, sh[p][7:1]};
      end
    end
  end

endmodule

// File: tb/tb_kbd_joypad.sv
// Scoreboard bench for kbd_joypad: three configurations share one stimulus
// stream, expectations are queued per event and popped by a monitor.
module tb_kbd_joypad;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_data = '0;
  logic       ps2_data_clk = 1'b0;
  logic       strobe_we = 1'b0;
  logic       strobe_din = 1'b0;
  logic       rd_en = 1'b0;
  logic       rd_port = 1'b0;
  logic       probe = 1'b0;

  logic        rd_a, rd_s, rd_o;
  logic [15:0] joy_a, joy_s;
  logic [7:0]  joy_o;

  logic byte_seen = 1'b0;
  logic rd_seen = 1'b0;
  logic probe_seen = 1'b0;

  int          q_dut [$];
  bit          q_rd [$];
  logic [15:0] q_exp [$];
  string       q_name [$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  kbd_joypad #(.PLAYERS(2), .SOCD(0)) dut_a (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk),
    .strobe_we(strobe_we), .strobe_din(strobe_din), .rd_en(rd_en), .rd_port(rd_port),
    .rd_bit(rd_a), .joy(joy_a)
  );

  kbd_joypad #(.PLAYERS(2), .SOCD(1)) dut_s (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk),
    .strobe_we(strobe_we), .strobe_din(strobe_din), .rd_en(rd_en), .rd_port(rd_port),
    .rd_bit(rd_s), .joy(joy_s)
  );

  kbd_joypad #(.PLAYERS(1), .SOCD(0)) dut_o (
    .clock(clock), .reset(reset), .ps2_data(ps2_data), .ps2_data_clk(ps2_data_clk),
    .strobe_we(strobe_we), .strobe_din(strobe_din), .rd_en(rd_en), .rd_port(rd_port),
    .rd_bit(rd_o), .joy(joy_o)
  );

  always @(posedge clock) begin
    byte_seen  <= ps2_data_clk;
    rd_seen    <= rd_en;
    probe_seen <= probe;
  end

  function automatic logic [15:0] actual_of(input int d, input bit is_rd);
    case (d)
      0:       return is_rd ? {15'b0, rd_a} : joy_a;
      1:       return is_rd ? {15'b0, rd_s} : joy_s;
      default: return is_rd ? {15'b0, rd_o} : {8'b0, joy_o};
    endcase
  endfunction

  // Monitor: once an event has reached the outputs, drain what was queued for it.
  always @(negedge clock) begin
    if (byte_seen || rd_seen || probe_seen) begin
      while (q_dut.size() > 0) begin
        int          d;
        bit          r;
        logic [15:0] e;
        logic [15:0] act;
        string       n;
        d = q_dut.pop_front();
        r = q_rd.pop_front();
        e = q_exp.pop_front();
        n = q_name.pop_front();
        act = actual_of(d, r);
        checks++;
        if (act !== e) begin
          errors++;
          $display("[TB] FAIL %s (dut %0d): got %h, expected %h", n, d, act, e);
        end
      end
    end
  end

  task automatic expect_joy(input int d, input logic [15:0] e, input string n);
    q_dut.push_back(d); q_rd.push_back(1'b0); q_exp.push_back(e); q_name.push_back(n);
  endtask

  task automatic expect_rd(input int d, input logic e, input string n);
    q_dut.push_back(d); q_rd.push_back(1'b1); q_exp.push_back({15'b0, e}); q_name.push_back(n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    ps2_data = b; ps2_data_clk = 1'b1;
    @(posedge clock); #1;
    ps2_data_clk = 1'b0;
    @(posedge clock);
  endtask

  task automatic cpu_read(input logic port);
    @(posedge clock); #1;
    rd_en = 1'b1; rd_port = port;
    @(posedge clock); #1;
    rd_en = 1'b0;
    @(posedge clock);
  endtask

  task automatic write_strobe(input logic v);
    @(posedge clock); #1;
    strobe_we = 1'b1; strobe_din = v;
    @(posedge clock); #1;
    strobe_we = 1'b0;
    @(posedge clock);
  endtask

  task automatic probe_now();
    @(posedge clock); #1;
    probe = 1'b1;
    @(posedge clock); #1;
    probe = 1'b0;
    @(posedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  logic port0_bits [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic p1_a_bits [8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    expect_joy(0, 16'h0000, "reset joy a");
    expect_joy(1, 16'h0000, "reset joy s");
    expect_joy(2, 16'h0000, "reset joy one");
    expect_rd(0, 1'b0, "reset rd_bit");
    probe_now();

    send_byte(8'hE0);
    pulse_reset();
    expect_joy(0, 16'h0000, "prefix dropped by reset");
    send_byte(8'h75);

    expect_joy(0, 16'h0001, "make Z");
    expect_joy(2, 16'h0001, "make Z one player");
    send_byte(8'h1A);
    send_byte(8'hF0);
    expect_joy(0, 16'h0000, "break Z");
    send_byte(8'h1A);

    send_byte(8'hE0);
    expect_joy(0, 16'h0010, "make E0 75");
    send_byte(8'h75);
    expect_joy(0, 16'h0010, "bare 75 ignored");
    send_byte(8'h75);
    expect_joy(0, 16'h0010, "E1 ignored");
    send_byte(8'hE1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    expect_joy(0, 16'h0000, "break E0 75");
    send_byte(8'h75);

    send_byte(8'h1A);
    send_byte(8'hE0);
    expect_joy(0, 16'h0081, "hold Z and Right");
    send_byte(8'h74);
    write_strobe(1'b1);
    write_strobe(1'b0);
    for (int i = 0; i < 10; i++) begin
      expect_rd(0, port0_bits[i], $sformatf("port0 read %0d", i + 1));
      expect_rd(2, port0_bits[i], $sformatf("port0 read %0d one player", i + 1));
      cpu_read(1'b0);
    end
    send_byte(8'hF0);
    send_byte(8'h1A);
    send_byte(8'hE0);
    send_byte(8'hF0);
    expect_joy(0, 16'h0000, "release Z and Right");
    send_byte(8'h74);

    send_byte(8'h1D);
    expect_joy(0, 16'h3000, "hold W and S");
    expect_joy(1, 16'h3000, "hold W and S socd");
    expect_joy(2, 16'h0000, "player1 keys inactive");
    send_byte(8'h1B);
    write_strobe(1'b1);
    write_strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_rd(0, p1_a_bits[i], $sformatf("port1 read %0d", i + 1));
      expect_rd(1, 1'b0, $sformatf("port1 read %0d socd", i + 1));
      expect_rd(2, 1'b0, $sformatf("port1 read %0d one player", i + 1));
      cpu_read(1'b1);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
    send_byte(8'hF0);
    send_byte(8'h1B);

    expect_joy(0, 16'h0100, "make J");
    send_byte(8'h3B);
    expect_joy(0, 16'h0100, "typematic J");
    send_byte(8'h3B);
    send_byte(8'hF0);
    expect_joy(0, 16'h0100, "break released K");
    send_byte(8'h42);
    write_strobe(1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_rd(0, 1'b1, $sformatf("strobe high port1 read %0d", i + 1));
      expect_rd(2, 1'b0, $sformatf("strobe high port1 read %0d one player", i + 1));
      cpu_read(1'b1);
    end
    expect_rd(0, 1'b0, "strobe high port0 read");
    cpu_read(1'b0);
    write_strobe(1'b0);
    expect_rd(0, 1'b1, "after strobe port1 A");
    cpu_read(1'b1);
    expect_rd(0, 1'b0, "after strobe port1 B");
    cpu_read(1'b1);

    repeat (3) @(posedge clock);
    if (q_dut.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", q_dut.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
